slc3_mem_ctrl: RTL and testbench

Memory/IO controller sitting directly downstream of the SLC3 datapath's MAR/MDR: turns single-cycle CPU access requests into multi-cycle strobe sequences on the off-chip 16-bit SRAM bus. Also services the memory-mapped switch/display port. It owns `A`, `Mem_bus` and all SRAM strobes. It returns read data and a one-cycle completion pulse to the CPU control FSM.

---
 rtl/slc3_pkg.sv | 24 ++
 rtl/slc3_mem_ctrl.sv | 148 ++++++++++++++
 tb/tb_slc3_mem_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/slc3_pkg.sv
// Shared SLC3 definitions: memory controller state encoding, the default
// switch/display address and SRAM strobe levels.
package slc3_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } mem_state_t;

   localparam logic [15:0] IO_ADDR_DEF = 16'hFFFF;

   // SRAM strobes are active-low.
   localparam logic STB_ON  = 1'b0;
   localparam logic STB_OFF = 1'b1;

   localparam int unsigned WAIT_CNT_W = 4;

   // The external SRAM has a 20-bit address; the CPU only reaches the low 64K words.
   function automatic logic [19:0] sram_addr(input logic [15:0] cpu_addr);
      return {4'h0, cpu_addr};
   endfunction

endpackage

// File: rtl/slc3_mem_ctrl.sv
// SLC3 memory/IO controller: turns single-cycle CPU requests into held SRAM
// strobe sequences and services the memory-mapped switch/display port.
module slc3_mem_ctrl
   import slc3_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [15:0] IO_ADDR     = IO_ADDR_DEF
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Req,
   input  logic        Wr,
   input  logic [15:0] Addr,
   input  logic [15:0] Wdata,
   output logic [15:0] Rdata,
   output logic        Ready,
   output logic        Busy,
   input  logic [15:0] S,
   output logic [15:0] Hex_data,
   output logic [19:0] A,
   inout  wire  [15:0] Mem_bus,
   output logic        CE_out,
   output logic        OE_out,
   output logic        WE_out,
   output logic        UB_out,
   output logic        LB_out
);

   localparam logic [WAIT_CNT_W-1:0] CNT_LOAD = WAIT_CNT_W'(WAIT_CYCLES - 1);

   mem_state_t             state_q;
   logic [WAIT_CNT_W-1:0]  cnt_q;
   logic [15:0]            addr_q;
   logic [15:0]            wdata_q;
   logic                   wr_q;
   logic [15:0]            rdata_q;
   logic [15:0]            hex_q;
   logic                   ready_q;
   logic                   busy_q;
   logic                   ce_q;
   logic                   oe_q;
   logic                   we_q;
   logic                   ub_q;
   logic                   lb_q;
   logic                   bus_oe_q;

   logic                   io_hit_d;
   logic                   cnt_zero_d;
   logic [WAIT_CNT_W-1:0]  cnt_d;

   always_comb begin
      io_hit_d   = (Addr == IO_ADDR);
      cnt_zero_d = (cnt_q == '0);
      cnt_d      = cnt_q - 1'b1;
   end

   // Every output is a flop so the pins are glitch-free; strobes change on
   // the same edges as the state register.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wr_q     <= 1'b0;
         rdata_q  <= '0;
         hex_q    <= '0;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
         ce_q     <= STB_OFF;
         oe_q     <= STB_OFF;
         we_q     <= STB_OFF;
         ub_q     <= STB_OFF;
         lb_q     <= STB_OFF;
         bus_oe_q <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (Req) begin
                  addr_q  <= Addr;
                  wdata_q <= Wdata;
                  wr_q    <= Wr;
                  busy_q  <= 1'b1;
                  if (io_hit_d) begin
                     state_q <= DONE;
                     ready_q <= 1'b1;
                     if (Wr) begin
                        hex_q <= Wdata;
                     end else begin
                        rdata_q <= S;
                     end
                  end else begin
                     state_q  <= ACCESS;
                     cnt_q    <= CNT_LOAD;
                     ce_q     <= STB_ON;
                     ub_q     <= STB_ON;
                     lb_q     <= STB_ON;
                     oe_q     <= Wr ? STB_OFF : STB_ON;
                     we_q     <= Wr ? STB_ON : STB_OFF;
                     bus_oe_q <= Wr;
                  end
               end
            end
            ACCESS: begin
               if (cnt_zero_d) begin
                  state_q  <= DONE;
                  ready_q  <= 1'b1;
                  ce_q     <= STB_OFF;
                  oe_q     <= STB_OFF;
                  we_q     <= STB_OFF;
                  ub_q     <= STB_OFF;
                  lb_q     <= STB_OFF;
                  bus_oe_q <= 1'b0;
                  // Last edge with OE low: the SRAM data has had the full hold window.
                  if (!wr_q) begin
                     rdata_q <= Mem_bus;
                  end
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign Mem_bus  = bus_oe_q ? wdata_q : 16'hzzzz;

   assign Rdata    = rdata_q;
   assign Ready    = ready_q;
   assign Busy     = busy_q;
   assign Hex_data = hex_q;
   assign A        = sram_addr(addr_q);
   assign CE_out   = ce_q;
   assign OE_out   = oe_q;
   assign WE_out   = we_q;
   assign UB_out   = ub_q;
   assign LB_out   = lb_q;

endmodule

// File: tb/tb_slc3_mem_ctrl.sv
// Bench for slc3_mem_ctrl: three instances (WAIT_CYCLES 2, 1, 4), each with a
// small SRAM behind its bus, a per-cycle reference timeline and directed checks.
module tb_slc3_mem_ctrl;

   localparam int NI = 3;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic        rst_n;
   logic [2:0]  req_r;
   logic [2:0]  wr_r;
   logic [15:0] addr_r  [NI];
   logic [15:0] wdata_r [NI];
   logic [15:0] sw;

   wire  [15:0] rdata_w [NI];
   wire  [15:0] hex_w   [NI];
   wire  [15:0] bus_w   [NI];
   wire  [19:0] a_w     [NI];
   wire  [2:0]  rdy_w, busy_w, ce_w, oe_w, we_w, ub_w, lb_w;

   int n_cmp  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   function automatic int wait_of(input int g);
      return (g == 0) ? 2 : ((g == 1) ? 1 : 4);
   endfunction

   function automatic logic [15:0] init_val(input int a);
      return 16'(a) ^ 16'h5A5A;
   endfunction

   function automatic bit released(input logic [15:0] v);
      return (v === 16'hzzzz) || (v === 16'h0000);
   endfunction

   generate
      for (genvar g = 0; g < NI; g++) begin : gi
         wire  [15:0] bus;
         logic [15:0] sram [0:255];

         initial begin
            for (int i = 0; i < 256; i++) sram[i] = init_val(i);
         end

         slc3_mem_ctrl #(
            .WAIT_CYCLES((g == 0) ? 2 : ((g == 1) ? 1 : 4)),
            .IO_ADDR    (16'hFFFF)
         ) u_dut (
            .Clk     (clk),
            .Reset   (rst_n),
            .Req     (req_r[g]),
            .Wr      (wr_r[g]),
            .Addr    (addr_r[g]),
            .Wdata   (wdata_r[g]),
            .Rdata   (rdata_w[g]),
            .Ready   (rdy_w[g]),
            .Busy    (busy_w[g]),
            .S       (sw),
            .Hex_data(hex_w[g]),
            .A       (a_w[g]),
            .Mem_bus (bus),
            .CE_out  (ce_w[g]),
            .OE_out  (oe_w[g]),
            .WE_out  (we_w[g]),
            .UB_out  (ub_w[g]),
            .LB_out  (lb_w[g])
         );

         assign bus = (!ce_w[g] && !oe_w[g] && we_w[g]) ? sram[a_w[g][7:0]] : 16'hzzzz;
         always @(posedge clk) begin
            if (!ce_w[g] && !we_w[g]) sram[a_w[g][7:0]] <= bus;
         end
         assign bus_w[g] = bus;
      end
   endgenerate

   // Reference: k = cycles since accept (-1 when idle). SRAM access occupies
   // k = 0..W-1 and completes at k = W; an IO access completes at k = 0.
   int          k_m  [NI];
   logic        io_m [NI];
   logic        wr_m [NI];
   logic [15:0] ad_m [NI];
   logic [15:0] wd_m [NI];
   logic [15:0] rd_m [NI];
   logic [15:0] hx_m [NI];
   logic [15:0] mmem [NI][0:255];

   initial begin
      for (int g = 0; g < NI; g++) begin
         k_m[g] = -1; io_m[g] = 1'b0; wr_m[g] = 1'b0;
         ad_m[g] = '0; wd_m[g] = '0; rd_m[g] = '0; hx_m[g] = '0;
         for (int i = 0; i < 256; i++) mmem[g][i] = init_val(i);
      end
   end

   always @(posedge clk or negedge rst_n) begin
      for (int g = 0; g < NI; g++) begin
         int lk;
         lk = io_m[g] ? 0 : wait_of(g);
         if (!rst_n) begin
            k_m[g] = -1; rd_m[g] = '0; hx_m[g] = '0; ad_m[g] = '0;
         end else if (k_m[g] >= 0) begin
            if (k_m[g] == lk) begin
               k_m[g] = -1;
            end else begin
               k_m[g]++;
               if (k_m[g] == lk) begin
                  if (wr_m[g]) mmem[g][ad_m[g][7:0]] = wd_m[g];
                  else         rd_m[g] = mmem[g][ad_m[g][7:0]];
               end
            end
         end else if (req_r[g]) begin
            k_m[g]  = 0;
            wr_m[g] = wr_r[g];
            ad_m[g] = addr_r[g];
            wd_m[g] = wdata_r[g];
            io_m[g] = (addr_r[g] == 16'hFFFF);
            if (io_m[g]) begin
               if (wr_r[g]) hx_m[g] = wdata_r[g];
               else         rd_m[g] = sw;
            end
         end
      end
   end

   task automatic cmpg(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d] @%0t: got %h expected %h", nm, g, $time, act, exp);
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      cmpg(nm, 0, act, exp);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int g = 0; g < NI; g++) begin
            int   lk;
            logic acc, done;
            lk   = io_m[g] ? 0 : wait_of(g);
            acc  = (k_m[g] >= 0) && !io_m[g] && (k_m[g] < lk);
            done = (k_m[g] >= 0) && (k_m[g] == lk);
            cmpg("CE",    g, 32'(ce_w[g]),  32'(!acc));
            cmpg("UB",    g, 32'(ub_w[g]),  32'(!acc));
            cmpg("LB",    g, 32'(lb_w[g]),  32'(!acc));
            cmpg("OE",    g, 32'(oe_w[g]),  32'(!(acc && !wr_m[g])));
            cmpg("WE",    g, 32'(we_w[g]),  32'(!(acc && wr_m[g])));
            cmpg("Ready", g, 32'(rdy_w[g]), 32'(done));
            cmpg("Busy",  g, 32'(busy_w[g]), 32'(k_m[g] >= 0));
            cmpg("A",     g, 32'(a_w[g]),   {12'h0, 4'h0, ad_m[g]});
            cmpg("Rdata", g, 32'(rdata_w[g]), 32'(rd_m[g]));
            cmpg("Hex",   g, 32'(hex_w[g]), 32'(hx_m[g]));
            if (acc && wr_m[g])  cmpg("BusWr", g, 32'(bus_w[g]), 32'(wd_m[g]));
            else if (!acc)       cmpg("BusZ",  g, 32'(released(bus_w[g])), 32'd1);
         end
      end
   end

   int ce_lo [NI], oe_lo [NI], we_lo [NI], rdy_cnt [NI];

   always @(negedge clk) begin
      for (int g = 0; g < NI; g++) begin
         if (ce_w[g] == 1'b0) ce_lo[g]++;
         if (oe_w[g] == 1'b0) oe_lo[g]++;
         if (we_w[g] == 1'b0) we_lo[g]++;
         if (rdy_w[g] == 1'b1) rdy_cnt[g]++;
      end
   end

   task automatic clr(input int g);
      ce_lo[g] = 0; oe_lo[g] = 0; we_lo[g] = 0; rdy_cnt[g] = 0;
   endtask

   task automatic txn(input int g, input logic w, input logic [15:0] ad,
                      input logic [15:0] wd, output int lat);
      lat = -1;
      @(negedge clk);
      req_r[g] = 1'b1; wr_r[g] = w; addr_r[g] = ad; wdata_r[g] = wd;
      for (int n = 1; n <= 24; n++) begin
         @(negedge clk);
         req_r[g] = 1'b0;
         if (rdy_w[g] === 1'b1) begin
            lat = n;
            break;
         end
      end
      if (lat < 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL timeout[%0d]: no Ready within 24 cycles", g);
      end
      @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      rst_n = 1'b0;
      req_r = '0;
      wr_r  = '0;
      sw    = '0;
      for (int g = 0; g < NI; g++) begin
         addr_r[g] = '0; wdata_r[g] = '0; clr(g);
      end
      repeat (2) @(negedge clk);
      chk_en = 1'b1;

      chk("rst_Rdata",   32'(rdata_w[0]), 32'h0);
      chk("rst_Hex",     32'(hex_w[0]),   32'h0);
      chk("rst_A",       32'(a_w[0]),     32'h0);
      chk("rst_Ready",   32'(rdy_w[0]),   32'h0);
      chk("rst_Busy",    32'(busy_w[0]),  32'h0);
      chk("rst_strobes", 32'({ce_w[0], oe_w[0], we_w[0], ub_w[0], lb_w[0]}), 32'h1F);
      chk("rst_bus",     32'(released(bus_w[0])), 32'd1);
      rst_n = 1'b1;
      @(negedge clk);

      // SRAM write then read back
      clr(0);
      txn(0, 1'b1, 16'h0010, 16'hBEEF, lat);
      chk("wr_lat",   32'(lat), 32'd3);
      chk("wr_WElow", 32'(we_lo[0]), 32'd2);
      chk("wr_OElow", 32'(oe_lo[0]), 32'd0);
      chk("wr_A",     32'(a_w[0]), 32'h00010);
      clr(0);
      txn(0, 1'b0, 16'h0010, 16'h0000, lat);
      chk("rd_lat",   32'(lat), 32'd3);
      chk("rd_data",  32'(rdata_w[0]), 32'hBEEF);
      chk("rd_OElow", 32'(oe_lo[0]), 32'd2);
      chk("rd_WElow", 32'(we_lo[0]), 32'd0);

      // IO read and IO write
      sw = 16'h000B;
      clr(0);
      txn(0, 1'b0, 16'hFFFF, 16'h0000, lat);
      chk("io_rd_lat",  32'(lat), 32'd1);
      chk("io_rd_data", 32'(rdata_w[0]), 32'h000B);
      chk("io_rd_CE",   32'(ce_lo[0]), 32'd0);
      clr(0);
      txn(0, 1'b1, 16'hFFFF, 16'h0014, lat);
      chk("io_wr_lat",   32'(lat), 32'd1);
      chk("io_wr_hex",   32'(hex_w[0]), 32'h0014);
      chk("io_wr_CE",    32'(ce_lo[0]), 32'd0);
      chk("io_wr_rdata", 32'(rdata_w[0]), 32'h000B);

      // Request during ACCESS is dropped
      clr(0);
      @(negedge clk);
      req_r[0] = 1'b1; wr_r[0] = 1'b0; addr_r[0] = 16'h0010;
      @(negedge clk);
      wr_r[0] = 1'b1; addr_r[0] = 16'h0020; wdata_r[0] = 16'hDEAD;
      @(negedge clk);
      req_r[0] = 1'b0;
      repeat (4) @(negedge clk);
      chk("drop_ready", 32'(rdy_cnt[0]), 32'd1);
      chk("drop_A",     32'(a_w[0]), 32'h00010);
      chk("drop_rdata", 32'(rdata_w[0]), 32'hBEEF);
      txn(0, 1'b0, 16'h0020, 16'h0000, lat);
      chk("drop_nowr",  32'(rdata_w[0]), 32'h5A7A);

      // Reset in the middle of a write
      @(negedge clk);
      req_r[0] = 1'b1; wr_r[0] = 1'b1; addr_r[0] = 16'h0030; wdata_r[0] = 16'h1234;
      @(negedge clk);
      req_r[0] = 1'b0;
      chk("mid_WE_pre", 32'(we_w[0]), 32'd0);
      #3 rst_n = 1'b0;
      #1;
      chk("mid_WE",  32'(we_w[0]), 32'd1);
      chk("mid_CE",  32'(ce_w[0]), 32'd1);
      chk("mid_bus", 32'(released(bus_w[0])), 32'd1);
      chk("mid_hex", 32'(hex_w[0]), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      clr(0);
      txn(0, 1'b0, 16'h0010, 16'h0000, lat);
      chk("post_lat",  32'(lat), 32'd3);
      chk("post_data", 32'(rdata_w[0]), 32'hBEEF);
      txn(0, 1'b0, 16'h0030, 16'h0000, lat);
      chk("post_nowr", 32'(rdata_w[0]), 32'h5A6A);

      // WAIT_CYCLES = 1 and 4
      clr(1);
      txn(1, 1'b1, 16'h0040, 16'h0F0F, lat);
      cmpg("w1_wr_lat", 1, 32'(lat), 32'd2);
      cmpg("w1_WElow",  1, 32'(we_lo[1]), 32'd1);
      clr(1);
      txn(1, 1'b0, 16'h0040, 16'h0000, lat);
      cmpg("w1_rd_lat", 1, 32'(lat), 32'd2);
      cmpg("w1_OElow",  1, 32'(oe_lo[1]), 32'd1);
      cmpg("w1_data",   1, 32'(rdata_w[1]), 32'h0F0F);
      clr(2);
      txn(2, 1'b1, 16'h0044, 16'hA5A5, lat);
      cmpg("w4_wr_lat", 2, 32'(lat), 32'd5);
      cmpg("w4_WElow",  2, 32'(we_lo[2]), 32'd4);
      clr(2);
      txn(2, 1'b0, 16'h0044, 16'h0000, lat);
      cmpg("w4_rd_lat", 2, 32'(lat), 32'd5);
      cmpg("w4_OElow",  2, 32'(oe_lo[2]), 32'd4);
      cmpg("w4_data",   2, 32'(rdata_w[2]), 32'hA5A5);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
